// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing (data width, parity, stop bits)
// feeding a first-word-fall-through receive FIFO with a valid/ready pop side.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic                          busy
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic                 sync1_q, sync2_q, prev_q;
  logic                 rxs;
  logic [2:0]           state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_err_q, par_err_d;
  logic                 stop_bad_q, stop_bad_d;
  logic                 frame_q, frame_d, parity_q, parity_d, overrun_q, overrun_d;
  logic                 expire, par_x, push, pop, full;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;

  assign rxs    = sync2_q;
  assign expire = (timer_q == TMR_W'(1));
  assign par_x  = (^shreg_q) ^ rxs;
  assign full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop    = rx_valid && rx_ready;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    par_err_d  = par_err_q;
    stop_bad_d = stop_bad_q;
    frame_d    = 1'b0;
    parity_d   = 1'b0;
    overrun_d  = 1'b0;
    push       = 1'b0;
    if (state_q != S_IDLE && state_q != S_BREAK && !expire)
      timer_d = timer_q - TMR_W'(1);
    case (state_q)
      S_IDLE: begin
        if (prev_q && !rxs) begin
          state_d = S_START;
          timer_d = TMR_W'(CLKS_PER_BIT / 2);
        end
      end
      S_START: begin
        if (expire) begin
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_DATA;
            timer_d    = TMR_W'(CLKS_PER_BIT);
            idx_d      = '0;
            par_err_d  = 1'b0;
            stop_bad_d = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (expire) begin
          // LSB arrives first; after DATA_BITS shifts it sits in bit 0
          shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
          timer_d = TMR_W'(CLKS_PER_BIT);
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (expire) begin
          par_err_d = (PARITY == 1) ? ~par_x : par_x;
          timer_d   = TMR_W'(CLKS_PER_BIT);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (expire) begin
          timer_d = TMR_W'(CLKS_PER_BIT);
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            state_d = S_IDLE;
            if (stop_bad_q || !rxs) begin
              frame_d = 1'b1;
              state_d = S_BREAK;
            end else if (par_err_q) begin
              parity_d = 1'b1;
            end else if (full && !pop) begin
              overrun_d = 1'b1;
            end else begin
              push = 1'b1;
            end
          end else begin
            stop_bad_d = stop_bad_q | ~rxs;
            idx_d      = idx_q + IDX_W'(1);
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= S_IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      par_err_q  <= 1'b0;
      stop_bad_q <= 1'b0;
      frame_q    <= 1'b0;
      parity_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= uart_rx;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      par_err_q  <= par_err_d;
      stop_bad_q <= stop_bad_d;
      frame_q    <= frame_d;
      parity_q   <= parity_d;
      overrun_q  <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    if (push) mem_q[wr_ptr_q] <= shreg_q;
  end

  // A full FIFO still accepts a push when the same cycle pops the head slot
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  assign rx_valid   = (count_q != '0);
  assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : '0;
  assign rx_count   = count_q;
  assign frame_err  = frame_q;
  assign parity_err = parity_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with an integrated receive FIFO, replacing the fixed 8N1, single-byte receive path feeding the pipeline CPU's UART peripheral. It synchronises the asynchronous `uart_rx` line, frames characters with configurable data width, parity and stop bits, and checks each character. Good characters are buffered in a first-word-fall-through FIFO behind a valid/ready interface. Frame, parity and overrun errors are reported as single-cycle pulses.

## Interface
- `CLKS_PER_BIT`, 10416: clock cycles per bit (100 MHz / 9600 baud); legal range ≥ 4.
- `DATA_BITS`, 8: data bits per character, 5..9, LSB first on the line.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `uart_rx`  in  1  asynchronous serial input; idle high.
- `rx_data`  out  DATA_BITS  head-of-FIFO character.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts `rx_data` when high together with `rx_valid`.
- `rx_count`  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `frame_err`  out  1  one-cycle pulse: a stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch.
- `overrun`  out  1  one-cycle pulse: good character dropped because the FIFO was full.
- `busy`  out  1  receiver is not in IDLE.

## Operation
- **Synchroniser:** 2-flop synchroniser on `uart_rx`, both flops reset to 1. All decisions use the synchronised signal `rxs`.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, BREAK. One bit-timer counter and one bit index.
- **IDLE:** a falling edge of `rxs` (previous 1, current 0) moves to START and loads the timer with CLKS_PER_BIT/2 (integer division).
- **START:** on timer expiry, sample `rxs`.
  - Sample 1: false start; return to IDLE with no flag.
  - Sample 0: go to DATA, reload the timer with CLKS_PER_BIT.
- **DATA:** on each expiry, shift `rxs` into bit position `index`. After DATA_BITS samples, go to PARITY if PARITY≠0, otherwise to STOP.
- **PARITY:** one sample.
  - Odd mode: the XOR of data and parity bits must be 1.
  - Even mode: that XOR must be 0.
  - The mismatch is latched; STOP follows.
- **STOP:** STOP_BITS samples, each required to be 1. At the final stop sample, exactly one outcome, in this priority:
  - Any stop bit 0: pulse `frame_err`, discard the character, go to BREAK.
  - Else parity mismatch: pulse `parity_err`, discard the character, go to IDLE.
  - Else FIFO full and no pop in this cycle: pulse `overrun`, discard, go to IDLE.
  - Else push the character and go to IDLE.
- **BREAK:** wait for `rxs` = 1, then go to IDLE. This stops a held-low line from producing repeated frames.
- **FIFO:** first-word-fall-through; `rx_data` is the head entry while `rx_valid` = 1.
  - Pop occurs when `rx_valid && rx_ready`.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leave the count unchanged and are legal even when full.
  - A pop when empty is ignored.
  - `rx_data` is don't-care while `rx_valid` = 0.
- **Reset:** any state, including mid-frame, returns to IDLE, empties the FIFO, and discards the partial character.

## Timing
- **Reset values:**
  - `rx_valid`, `rx_count`, `frame_err`, `parity_err`, `overrun`, `busy` = 0.
  - `rx_data` = 0.
  - Synchroniser flops = 1.
- **Synchroniser latency:** 2 cycles from `uart_rx` to `rxs`.
- **Sample points:** with the falling edge of `rxs` seen at cycle t, the start bit is sampled at t + CLKS_PER_BIT/2. Bit k after the start bit (data, then parity, then stop) is sampled at t + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- **Outcome latency:** push, or one of the error pulses, is registered at the final stop-sample edge. `rx_valid` and `rx_count` update on the next cycle.
- **Error pulses:** each lasts exactly one cycle; at most one pulses per character.
- **`busy`:** high from the cycle after edge detection until IDLE is re-entered.
- **Back-to-back frames:** a new start edge is accepted in the first IDLE cycle after the stop sample. No extra stop time is required beyond STOP_BITS.

## Test plan
All scenarios use CLKS_PER_BIT = 16.
- **Defaults 8N1:** send 0xB4, then 0x97, with `rx_ready` = 0. Required: `rx_count` = 2, `rx_data` = 0xB4. Then pulse `rx_ready` one cycle → `rx_data` = 0x97, `rx_count` = 1. No error pulses.
- **PARITY = 2 (even):** send 0x0F with parity bit 0 → accepted. Send 0x0F with parity bit 1 → `parity_err` pulses once, `rx_count` unchanged.
- **Frame error:** stop bit driven 0 after 0x55, line then held low for 40 bit times. Required: exactly one `frame_err` pulse, `busy` stays high (BREAK) until the line returns high, no character pushed.
- **Overrun, FIFO_DEPTH = 4:** send 5 characters 0x01..0x05 with `rx_ready` = 0. Required: one `overrun` pulse on the 5th, FIFO holds 0x01..0x04. Repeat with `rx_ready` held 1 during the 5th stop sample: no overrun, all five delivered in order.
- **Glitch and mid-frame reset:** a 3-cycle low glitch on idle line → no character, `busy` returns to 0 within CLKS_PER_BIT/2 + 3 cycles. Assert `reset` for one cycle mid-DATA, then send 0xA5 → exactly one character 0xA5 received.
- **DATA_BITS = 5, STOP_BITS = 2:** send 0x1B → `rx_data` = 0x1B. Second stop bit driven 0 → `frame_err`.
